// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO that uses the same handshake as the async
// FIFO (winc/wdata/wfull on the write side, rinc/rdata/rempty on the read side).
// Binary pointers are one bit wider than the address, and that extra MSB is
// the wrap bit. Flags and count are registered. They are computed from the
// next-state pointers, so they update in the same cycle as the pointers.
// Optional feature: define FIFO_ERR_FLAGS_EN to add the sticky overflow and
// underflow outputs.
module modport_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt;
  logic                w_acc, r_acc;

  // Requests are blocked by the current registered flags; pointers advance on accept
  always_comb begin
    w_acc    = winc & ~wfull;
    r_acc    = rinc & ~rempty;
    wptr_nxt = wptr + {{ADDR_WIDTH{1'b0}}, w_acc};
    rptr_nxt = rptr + {{ADDR_WIDTH{1'b0}}, r_acc};
  end

  // Storage array has no reset; the pointer reset makes stale contents unreachable
  always_ff @(posedge wclk) begin
    if (!wrst && w_acc)
      mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
  end

  // Pointers, registered read data, and flags derived from the next pointers
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr   <= '0;
      rptr   <= '0;
      rdata  <= '0;
      wfull  <= 1'b0;
      rempty <= 1'b1;
      count  <= '0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      if (r_acc)
        rdata <= mem[rptr[ADDR_WIDTH-1:0]];
      rempty <= (wptr_nxt == rptr_nxt);
      wfull  <= (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
      count  <= wptr_nxt - rptr_nxt;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; only reset clears them
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo: directed and random stimulus for modport_fifo. The
// expected behaviour comes from a queue-based model of FIFO occupancy.
module tb_modport_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          wfull, rempty;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  modport_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wclk  (wclk),
    .wrst  (wrst),
    .wdata (wdata),
    .winc  (winc),
    .wfull (wfull),
    .rinc  (rinc),
    .rdata (rdata),
    .rempty(rempty),
    .count (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 wclk = ~wclk;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] rd_m;
  bit            ovf_m, unf_m;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("count",  32'(count),  32'(q.size()));
    chk("rempty", 32'(rempty), 32'(q.size() == 0));
    chk("wfull",  32'(wfull),  32'(q.size() == DEPTH));
    chk("rdata",  32'(rdata),  32'(rd_m));
    chk("not_full_and_empty", 32'(wfull & rempty), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",  32'(overflow),  32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
`endif
  endtask

  // Apply one clock with the given inputs, advance the model, then check the outputs
  task automatic step(input bit rst, input bit w, input logic [DW-1:0] d, input bit r);
    bit full, empty;
    wrst = rst; winc = w; wdata = d; rinc = r;
    @(posedge wclk);
    if (rst) begin
      q.delete();
      rd_m  = '0;
      ovf_m = 0;
      unf_m = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (w && full)  ovf_m = 1;
      if (r && empty) unf_m = 1;
      if (r && !empty) rd_m = q.pop_front();
      if (w && !full)  q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    rd_m = '0; ovf_m = 0; unf_m = 0;

    // reset held with both requests active
    step(1, 1, 8'h55, 1);
    step(1, 1, 8'h66, 1);
    chk("reset_count", 32'(count), 32'd0);

    // fill with 0x00..0x0F, then attempt a write while full
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i), 0);
    chk("full_after_16", 32'(wfull), 32'd1);
    step(0, 1, 8'hAA, 0);
    chk("count_full_blocked", 32'(count), 32'd16);

    // drain and check that the data comes back in order
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 8'h00, 1);
      chk("drain_order", 32'(rdata), 32'(i));
    end
    chk("empty_after_drain", 32'(rempty), 32'd1);

    // read while empty: rdata holds
    step(0, 0, 8'h00, 1);
    chk("underflow_rdata_hold", 32'(rdata), 32'h0F);

    // clear, then run simultaneous traffic at an occupancy of 5
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'($urandom), 0);
    for (int i = 0; i < 10; i++) step(0, 1, DW'($urandom), 1);
    chk("simul_count5", 32'(count), 32'd5);

    // full with both requests: only the read is accepted
    while (q.size() < DEPTH) step(0, 1, DW'($urandom), 0);
    step(0, 1, DW'($urandom), 1);
    chk("full_both_count", 32'(count), 32'd15);
    chk("full_both_wfull", 32'(wfull), 32'd0);

    // empty with both requests: only the write is accepted, no fall-through
    while (q.size() > 0) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h3C, 1);
    chk("empty_both_count", 32'(count), 32'd1);

    // wrap: keep occupancy between 1 and 15 across many pointer wraps
    for (int i = 0; i < 120; i++) begin
      bit w, r;
      w = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH - 1);
      r = ($urandom_range(0, 1) == 1) && (q.size() > 1);
      step(0, w, DW'($urandom), r);
    end

    // mid-operation reset at an occupancy of 7
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) step(0, 1, DW'($urandom), 0);
    chk("pre_reset_count", 32'(count), 32'd7);
    step(1, 1, 8'hEE, 1);
    chk("midreset_count", 32'(count), 32'd0);
    step(0, 1, 8'hC3, 0);
    step(0, 0, 8'h00, 1);
    chk("post_reset_data", 32'(rdata), 32'hC3);

    // fully random traffic, including blocked requests
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
           DW'($urandom), $urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
